// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Op codes follow RV32M funct3; states use plain localparams.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic is_div(input logic [2:0] funct);
        return funct[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or
// restoring shift-subtract divide on a 2*WIDTH accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opb,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0]   w_msum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // Multiply: low half holds the remaining multiplier bits, high half
    // the partial product; divide: high half is the partial remainder,
    // low half shifts the dividend out and the quotient in.
    always_comb begin
        w_msum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
        if (i_acc[0]) begin
            w_msum = w_msum + {1'b0, i_opb};
        end
        w_trial = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_diff  = w_trial - {1'b0, i_opb};
        w_fits  = (w_trial >= {1'b0, i_opb});
        if (i_is_div) begin
            if (w_fits) begin
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_msum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_e.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Stalls the pipeline while busy and pulses DoneE with ResultE.
module muldiv_e
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StartE,
    input  logic [2:0]        FunctE,
    input  logic [WIDTH-1:0]  SrcAE,
    input  logic [WIDTH-1:0]  SrcBE,
    input  logic              FlushE,
    output logic [WIDTH-1:0]  ResultE,
    output logic              DoneE,
    output logic              StallReqE
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_op;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_b;
    logic                 r_neg;
    logic [WIDTH-1:0]     r_result;

    logic                 w_a_signed;
    logic                 w_b_signed;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_neg;
    logic                 w_div0;
    logic                 w_ovf;
    logic                 w_special;
    logic [WIDTH-1:0]     w_special_res;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_prod_neg;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_r;
    logic [WIDTH-1:0]     w_fin;
    logic                 w_last;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (is_div(r_op)),
        .i_acc    (r_acc),
        .i_opb    (r_b),
        .o_acc    (w_acc_nxt)
    );

    // Issue-cycle decode: operand signs, magnitudes and special divides.
    always_comb begin
        w_a_signed = (FunctE == OP_MUL) || (FunctE == OP_MULH) ||
                     (FunctE == OP_MULHSU) || (FunctE == OP_DIV) ||
                     (FunctE == OP_REM);
        w_b_signed = (FunctE == OP_MUL) || (FunctE == OP_MULH) ||
                     (FunctE == OP_DIV) || (FunctE == OP_REM);
        w_sa    = w_a_signed & SrcAE[WIDTH-1];
        w_sb    = w_b_signed & SrcBE[WIDTH-1];
        w_mag_a = w_sa ? (~SrcAE + 1'b1) : SrcAE;
        w_mag_b = w_sb ? (~SrcBE + 1'b1) : SrcBE;
        // Remainder takes the dividend sign; everything else is A xor B.
        w_neg   = (FunctE == OP_REM) ? w_sa : (w_sa ^ w_sb);
        w_div0  = is_div(FunctE) && (SrcBE == '0);
        w_ovf   = ((FunctE == OP_DIV) || (FunctE == OP_REM)) &&
                  (SrcAE == MIN_INT) && (SrcBE == '1);
        w_special = w_div0 | w_ovf;
        if (w_div0) begin
            w_special_res = FunctE[1] ? SrcAE : '1;
        end else begin
            w_special_res = FunctE[1] ? '0 : MIN_INT;
        end
    end

    // Final-iteration sign fix-up and result selection.
    always_comb begin
        w_prod_neg = ~w_acc_nxt + 1'b1;
        w_prod     = r_neg ? w_prod_neg : w_acc_nxt;
        w_q        = w_acc_nxt[WIDTH-1:0];
        w_r        = w_acc_nxt[2*WIDTH-1:WIDTH];
        case (r_op)
            OP_MUL:           w_fin = w_prod[WIDTH-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:         w_fin = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:  w_fin = r_neg ? (~w_q + 1'b1) : w_q;
            default:          w_fin = r_neg ? (~w_r + 1'b1) : w_r;
        endcase
    end

    assign w_last = (r_state == S_BUSY) && (r_cnt == CW'(WIDTH-1));

    // FSM, iteration counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (FlushE) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (StartE) begin
                        r_op  <= FunctE;
                        r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                        r_b   <= w_mag_b;
                        r_neg <= w_neg;
                        r_cnt <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result <= w_fin;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ResultE   = r_result;
    assign DoneE     = (r_state == S_DONE);
    assign StallReqE = !rst && (((r_state == S_IDLE) && StartE) ||
                                (r_state == S_BUSY));

endmodule

// File: tb/tb_muldiv_e.sv
// Self-checking bench for muldiv_e: directed table, random ops
// against an arithmetic model, and flush/reset/back-to-back cases.
module tb_muldiv_e;

    logic        clk = 1'b0;
    logic        rst;
    logic        StartE;
    logic [2:0]  FunctE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic [31:0] ResultE;
    logic        DoneE;
    logic        StallReqE;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_e #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .StartE    (StartE),
        .FunctE    (FunctE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .ResultE   (ResultE),
        .DoneE     (DoneE),
        .StallReqE (StallReqE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'b000: begin p = 64'(sa * sb); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = 64'(ua * ub); return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    return 32'h80000000;
                return 32'(sa / sb);
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'b100 || op == 3'b110) &&
            a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Issues one op from IDLE and waits (bounded) for DoneE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output bit stall_ok);
        @(negedge clk);
        StartE = 1'b1;
        FunctE = op;
        SrcAE  = a;
        SrcBE  = b;
        lat = -1;
        res = 'x;
        stall_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (DoneE) begin
                lat = k;
                res = ResultE;
                if (StallReqE) stall_ok = 1'b0;
                break;
            end
            if (!StallReqE) stall_ok = 1'b0;
            @(negedge clk);
        end
        StartE = 1'b0;
    endtask

    task automatic do_vec(input string name, input vec_t v);
        logic [31:0] res;
        int lat;
        bit sok;
        run_op(v.op, v.a, v.b, res, lat, sok);
        chk({name, "_res"}, res, v.exp);
        chk({name, "_lat"}, 32'(lat), 32'(v.lat));
        chk({name, "_stall"}, {31'd0, sok}, 32'd1);
    endtask

    vec_t tbl[12];
    logic [31:0] last_res;
    logic [31:0] res;
    int lat;
    bit sok;
    bit seen_done;
    bit seen_stall;

    initial begin
        rst = 1'b1;
        StartE = 1'b1;
        FunctE = 3'b000;
        SrcAE = 32'd1;
        SrcBE = 32'd1;
        FlushE = 1'b0;

        tbl[0]  = '{3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        tbl[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        tbl[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        tbl[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        tbl[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33};
        tbl[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33};
        tbl[6]  = '{3'b101, 32'd100, 32'd7, 32'd14, 33};
        tbl[7]  = '{3'b111, 32'd100, 32'd7, 32'd2, 33};
        tbl[8]  = '{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1};
        tbl[9]  = '{3'b111, 32'd5, 32'd0, 32'd5, 1};
        tbl[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        tbl[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};

        // Reset with StartE high: stall must be suppressed.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, StallReqE}, 32'd0);
        chk("rst_done", {31'd0, DoneE}, 32'd0);
        chk("rst_result", ResultE, 32'd0);
        StartE = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_stall", {31'd0, StallReqE}, 32'd0);
        chk("idle_done", {31'd0, DoneE}, 32'd0);

        foreach (tbl[i]) begin
            do_vec($sformatf("vec%0d", i), tbl[i]);
        end
        last_res = tbl[11].exp;

        // Random ops against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.op = 3'($urandom_range(0, 7));
            v.a = $urandom;
            v.b = $urandom;
            case ($urandom_range(0, 7))
                0: v.b = 32'd0;
                1: v.b = 32'hFFFFFFFF;
                2: v.a = 32'h80000000;
                3: v.b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            v.exp = model(v.op, v.a, v.b);
            v.lat = model_lat(v.op, v.a, v.b);
            do_vec($sformatf("rnd%0d_op%0d", i, v.op), v);
            last_res = v.exp;
        end

        // Flush at cycle 10 of a DIVU.
        @(negedge clk);
        StartE = 1'b1; FunctE = 3'b101;
        SrcAE = 32'd1000; SrcBE = 32'd3;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        #1;
        chk("flush_c10_stall", {31'd0, StallReqE}, 32'd1);
        FlushE = 1'b1;
        StartE = 1'b0;
        @(negedge clk);
        FlushE = 1'b0;
        #1;
        chk("flush_c11_stall", {31'd0, StallReqE}, 32'd0);
        seen_done = 1'b0;
        seen_stall = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (DoneE) seen_done = 1'b1;
            if (StallReqE) seen_stall = 1'b1;
            @(negedge clk);
            #1;
        end
        chk("flush_no_done", {31'd0, seen_done}, 32'd0);
        chk("flush_no_stall", {31'd0, seen_stall}, 32'd0);
        chk("flush_result", ResultE, last_res);

        // Reset at cycle 10 of a DIVU.
        @(negedge clk);
        StartE = 1'b1; FunctE = 3'b101;
        SrcAE = 32'd1000; SrcBE = 32'd3;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        rst = 1'b1;
        StartE = 1'b0;
        #1;
        chk("rstmid_c10_stall", {31'd0, StallReqE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_c11_stall", {31'd0, StallReqE}, 32'd0);
        chk("rstmid_result", ResultE, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (DoneE) seen_done = 1'b1;
            @(negedge clk);
            #1;
        end
        chk("rstmid_no_done", {31'd0, seen_done}, 32'd0);

        // Back-to-back MULs with StartE held through DONE.
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, res, lat, sok);
        StartE = 1'b1;
        chk("b2b1_res", res, 32'hFFFFFFEB);
        chk("b2b1_lat", 32'(lat), 32'd33);
        chk("b2b1_done_stall", {31'd0, StallReqE}, 32'd0);
        SrcAE = 32'd12345;
        SrcBE = 32'hFFFFF000;
        @(negedge clk);
        #1;
        chk("b2b2_issue_stall", {31'd0, StallReqE}, 32'd1);
        chk("b2b2_issue_done", {31'd0, DoneE}, 32'd0);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (DoneE) begin
                lat = k;
                break;
            end
            @(negedge clk);
            #1;
        end
        StartE = 1'b0;
        chk("b2b2_lat", 32'(lat), 32'd33);
        chk("b2b2_res", ResultE, model(3'b000, 32'd12345, 32'hFFFFF000));
        @(negedge clk);
        #1;
        chk("b2b2_after_done", {31'd0, DoneE}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
